// File: rtl/xdn_cpu_pkg.sv
// Shared CPU definitions used by the instruction queue and the control unit.
// Holds the default bus/opcode widths, opcode field values and a small
// helper for splitting an instruction word into its fields.
package xdn_cpu_pkg;

    localparam int XDN_DATA_WIDTH   = 8;
    localparam int XDN_OPCODE_WIDTH = XDN_DATA_WIDTH / 2;

    // Opcode field values decoded by the control unit (upper nibble of a word).
    localparam logic [XDN_OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [XDN_OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [XDN_OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [XDN_OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [XDN_OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [XDN_OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    // Even parity of a default-width bus word, for bus integrity monitors.
    function automatic logic word_parity(input logic [XDN_DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Synchronous prefetch FIFO (DEPTH x DATA_WIDTH) for the instruction queue.
// Ports: clk/rst_n (async active-low), clear (sync empty), push/din (write
// tail), pop (advance head), head (current head word), count (occupancy),
// full/empty (registered, consistent with count).
// A push while full without a pop and a pop while empty are ignored.
module ir_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Pop frees a slot on the same edge, so a full FIFO can still accept a push.
    assign do_pop_s  = pop & ~empty_r & ~clear;
    assign do_push_s = push & (~full_r | do_pop_s) & ~clear;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        if (clear) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (do_push_s && !do_pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and flag registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    // Storage array; contents are don't-care outside the live window.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/instruction_queue.sv
// Instruction prefetch queue with current-instruction register (CIR).
// Ports: i_CLOCK, i_CLEAR_n (async reset), BUS (shared tri-state data bus),
// i_READ_BUS_n (push BUS word), i_WRITE_BUS_n (drive CIR operand on BUS),
// i_NEXT_n (retire CIR), i_FLUSH_n (sync flush), o_OPCODE/o_OPERAND (CIR
// fields), o_VALID, o_COUNT/o_FULL/o_EMPTY (FIFO status, CIR excluded),
// o_OVERFLOW (sticky dropped-push flag).
module instruction_queue
    import xdn_cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = XDN_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DATA_WIDTH / 2,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                             i_CLOCK,
    input  logic                             i_CLEAR_n,
    inout  wire  [DATA_WIDTH-1:0]            BUS,
    input  logic                             i_READ_BUS_n,
    input  logic                             i_WRITE_BUS_n,
    input  logic                             i_NEXT_n,
    input  logic                             i_FLUSH_n,
    output logic [OPCODE_WIDTH-1:0]          o_OPCODE,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] o_OPERAND,
    output logic                             o_VALID,
    output logic [CNT_W-1:0]                 o_COUNT,
    output logic                             o_FULL,
    output logic                             o_EMPTY,
    output logic                             o_OVERFLOW
);

    localparam int OPERAND_W = DATA_WIDTH - OPCODE_WIDTH;

    logic [DATA_WIDTH-1:0] cir_r;
    logic [DATA_WIDTH-1:0] cir_nxt_s;
    logic                  valid_r;
    logic                  valid_nxt_s;
    logic                  ovf_r;
    logic                  ovf_nxt_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  retire_s;
    logic                  flush_s;
    logic                  cir_free_s;
    logic                  pop_s;
    logic                  bypass_s;
    logic                  fifo_push_s;
    logic                  drop_s;

    // Both bus enables low is illegal: the drive wins and the push is suppressed.
    assign push_s     = ~i_READ_BUS_n & i_WRITE_BUS_n;
    assign retire_s   = ~i_NEXT_n & valid_r;
    assign flush_s    = ~i_FLUSH_n;
    assign cir_free_s = ~valid_r | retire_s;
    assign pop_s      = ~flush_s & cir_free_s & ~fifo_empty_s;
    // Bypass only when nothing is queued, so FIFO order is never violated.
    assign bypass_s   = ~flush_s & cir_free_s & fifo_empty_s & push_s;
    assign fifo_push_s = ~flush_s & push_s & ~bypass_s;
    assign drop_s     = fifo_push_s & fifo_full_s & ~pop_s;

    ir_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_ir_fifo (
        .clk   (i_CLOCK),
        .rst_n (i_CLEAR_n),
        .clear (flush_s),
        .push  (fifo_push_s),
        .pop   (pop_s),
        .din   (BUS),
        .head  (head_s),
        .count (o_COUNT),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // CIR load priority: flush, then FIFO head, then bypass, then retire-to-empty.
    always_comb begin
        cir_nxt_s   = cir_r;
        valid_nxt_s = valid_r;
        ovf_nxt_s   = ovf_r;
        if (flush_s) begin
            cir_nxt_s   = {DATA_WIDTH{1'b0}};
            valid_nxt_s = 1'b0;
            ovf_nxt_s   = 1'b0;
        end else begin
            if (pop_s) begin
                cir_nxt_s   = head_s;
                valid_nxt_s = 1'b1;
            end else if (bypass_s) begin
                cir_nxt_s   = BUS;
                valid_nxt_s = 1'b1;
            end else if (retire_s) begin
                cir_nxt_s   = {DATA_WIDTH{1'b0}};
                valid_nxt_s = 1'b0;
            end else begin
                cir_nxt_s   = cir_r;
                valid_nxt_s = valid_r;
            end
            if (drop_s) begin
                ovf_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
        end
    end

    // CIR, valid and sticky overflow registers.
    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            cir_r   <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            cir_r   <= cir_nxt_s;
            valid_r <= valid_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Reset gates the driver so the bus is released the moment i_CLEAR_n falls.
    assign BUS = (!i_WRITE_BUS_n && i_CLEAR_n)
               ? {{OPCODE_WIDTH{1'b0}}, cir_r[OPERAND_W-1:0]}
               : {DATA_WIDTH{1'bz}};

    assign o_OPCODE   = cir_r[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign o_OPERAND  = cir_r[OPERAND_W-1:0];
    assign o_VALID    = valid_r;
    assign o_FULL     = fifo_full_s;
    assign o_EMPTY    = fifo_empty_s;
    assign o_OVERFLOW = ovf_r;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_instruction_queue;

    localparam int DEPTH = 4;

    logic       i_CLOCK;
    logic       i_CLEAR_n;
    wire  [7:0] BUS;
    logic       i_READ_BUS_n;
    logic       i_WRITE_BUS_n;
    logic       i_NEXT_n;
    logic       i_FLUSH_n;
    logic [3:0] o_OPCODE;
    logic [3:0] o_OPERAND;
    logic       o_VALID;
    logic [2:0] o_COUNT;
    logic       o_FULL;
    logic       o_EMPTY;
    logic       o_OVERFLOW;

    logic       tb_drv_en;
    logic [7:0] tb_drv_val;

    int checks;
    int failures;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_cir;
    logic       m_valid;
    logic       m_ovf;

    assign BUS = tb_drv_en ? tb_drv_val : 8'bz;

    instruction_queue dut (
        .i_CLOCK       (i_CLOCK),
        .i_CLEAR_n     (i_CLEAR_n),
        .BUS           (BUS),
        .i_READ_BUS_n  (i_READ_BUS_n),
        .i_WRITE_BUS_n (i_WRITE_BUS_n),
        .i_NEXT_n      (i_NEXT_n),
        .i_FLUSH_n     (i_FLUSH_n),
        .o_OPCODE      (o_OPCODE),
        .o_OPERAND     (o_OPERAND),
        .o_VALID       (o_VALID),
        .o_COUNT       (o_COUNT),
        .o_FULL        (o_FULL),
        .o_EMPTY       (o_EMPTY),
        .o_OVERFLOW    (o_OVERFLOW)
    );

    initial i_CLOCK = 1'b0;
    always #5 i_CLOCK = ~i_CLOCK;

    task automatic model_reset();
        m_q.delete();
        m_cir   = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of queue behaviour, stated in terms of the word queue.
    task automatic model_edge(input logic rd_n, input logic wr_n, input logic nx_n,
                              input logic fl_n, input logic [7:0] d);
        logic push;
        logic retire;
        logic free;
        push   = !rd_n && wr_n;
        retire = !nx_n && m_valid;
        free   = !m_valid || retire;
        if (!fl_n) begin
            model_reset();
        end else begin
            if (free && m_q.size() > 0) begin
                m_cir   = m_q.pop_front();
                m_valid = 1'b1;
            end else if (free && push) begin
                m_cir   = d;
                m_valid = 1'b1;
                push    = 1'b0;
            end else if (retire) begin
                m_cir   = 8'h00;
                m_valid = 1'b0;
            end
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic set_idle();
        i_READ_BUS_n  = 1'b1;
        i_WRITE_BUS_n = 1'b1;
        i_NEXT_n      = 1'b1;
        i_FLUSH_n     = 1'b1;
        tb_drv_en     = 1'b0;
        tb_drv_val    = 8'h00;
    endtask

    // Apply one set of controls across a rising edge; returns #1 after it.
    task automatic cycle(input logic rd_n, input logic wr_n, input logic nx_n,
                         input logic fl_n, input logic [7:0] d);
        i_READ_BUS_n  = rd_n;
        i_WRITE_BUS_n = wr_n;
        i_NEXT_n      = nx_n;
        i_FLUSH_n     = fl_n;
        tb_drv_en     = wr_n;
        tb_drv_val    = d;
        model_edge(rd_n, wr_n, nx_n, fl_n, d);
        @(posedge i_CLOCK);
        #1;
        set_idle();
    endtask

    task automatic push_word(input logic [7:0] d, input logic nx_n);
        cycle(1'b0, 1'b1, nx_n, 1'b1, d);
    endtask

    task automatic test_reset();
        set_idle();
        i_CLEAR_n = 1'b0;
        model_reset();
        repeat (2) @(posedge i_CLOCK);
        #1;
        checks++;
        if ({o_OPCODE, o_OPERAND} !== 8'h00) begin
            failures++;
            $display("FAIL reset_cir got=%h want=00", {o_OPCODE, o_OPERAND});
        end
        checks++;
        if ({o_VALID, o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW} !== 7'b0_000_0_1_0) begin
            failures++;
            $display("FAIL reset_status got v=%b c=%0d f=%b e=%b o=%b want v=0 c=0 f=0 e=1 o=0",
                     o_VALID, o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW);
        end
        #3;
        i_CLEAR_n = 1'b1;
        @(posedge i_CLOCK);
        #1;
    endtask

    task automatic test_bypass();
        push_word(8'hA5, 1'b1);
        checks++;
        if ({o_OPCODE, o_OPERAND, o_VALID, o_COUNT} !== {4'hA, 4'h5, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL bypass got op=%h opr=%h v=%b c=%0d want op=a opr=5 v=1 c=0",
                     o_OPCODE, o_OPERAND, o_VALID, o_COUNT);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] words [5];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            push_word(words[i], 1'b1);
            if (i == 2) begin
                checks++;
                if (o_COUNT !== 3'd3 || o_FULL !== 1'b0 || o_OVERFLOW !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_partial got c=%0d f=%b o=%b want c=3 f=0 o=0",
                             o_COUNT, o_FULL, o_OVERFLOW);
                end
            end
        end
        checks++;
        if ({o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL fill_full got c=%0d f=%b e=%b o=%b want c=4 f=1 e=0 o=1",
                     o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW);
        end
        checks++;
        if ({o_OPCODE, o_OPERAND} !== 8'hA5) begin
            failures++;
            $display("FAIL fill_cir_held got=%h want=a5", {o_OPCODE, o_OPERAND});
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
            checks++;
            if ({o_OPCODE, o_OPERAND} !== words[i] || o_VALID !== 1'b1
                || o_COUNT !== 3'(3 - i)) begin
                failures++;
                $display("FAIL retire_seq%0d got cir=%h v=%b c=%0d want cir=%h v=1 c=%0d",
                         i, {o_OPCODE, o_OPERAND}, o_VALID, o_COUNT, words[i], 3 - i);
            end
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) push_word(8'hB1 + 8'(i), 1'b1);
        checks++;
        if (o_FULL !== 1'b1 || {o_OPCODE, o_OPERAND} !== 8'h44) begin
            failures++;
            $display("FAIL refill got f=%b cir=%h want f=1 cir=44", o_FULL, {o_OPCODE, o_OPERAND});
        end
        push_word(8'h66, 1'b0);
        checks++;
        if ({o_OPCODE, o_OPERAND} !== 8'hB1 || o_COUNT !== 3'd4 || o_OVERFLOW !== 1'b1) begin
            failures++;
            $display("FAIL full_push_pop got cir=%h c=%0d o=%b want cir=b1 c=4 o=1",
                     {o_OPCODE, o_OPERAND}, o_COUNT, o_OVERFLOW);
        end
        // Drain to confirm 0x66 landed at the tail behind B2..B4.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({o_OPCODE, o_OPERAND} !== 8'h66 || o_EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL full_push_tail got cir=%h e=%b want cir=66 e=1",
                     {o_OPCODE, o_OPERAND}, o_EMPTY);
        end
        for (int i = 0; i < 2; i++) push_word(8'hC0 + 8'(i), 1'b1);
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
        checks++;
        if ({o_VALID, o_COUNT, o_EMPTY, o_OVERFLOW} !== {1'b0, 3'd0, 1'b1, 1'b0}
            || {o_OPCODE, o_OPERAND} !== 8'h00) begin
            failures++;
            $display("FAIL flush got v=%b c=%0d e=%b o=%b cir=%h want v=0 c=0 e=1 o=0 cir=00",
                     o_VALID, o_COUNT, o_EMPTY, o_OVERFLOW, {o_OPCODE, o_OPERAND});
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        checks++;
        if (o_VALID !== 1'b0 || o_COUNT !== 3'd0) begin
            failures++;
            $display("FAIL flush_discard got v=%b c=%0d want v=0 c=0", o_VALID, o_COUNT);
        end
    endtask

    task automatic test_bus_drive();
        push_word(8'h3C, 1'b1);
        i_WRITE_BUS_n = 1'b0;
        #1;
        checks++;
        if (BUS !== 8'h0C) begin
            failures++;
            $display("FAIL bus_drive got=%h want=0c", BUS);
        end
        // Released bus: a bench-driven probe must read back undisturbed.
        i_WRITE_BUS_n = 1'b1;
        tb_drv_en     = 1'b1;
        tb_drv_val    = 8'h50;
        #1;
        checks++;
        if (BUS !== 8'h50) begin
            failures++;
            $display("FAIL bus_release got=%h want=50", BUS);
        end
        set_idle();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        i_READ_BUS_n  = 1'b0;
        i_WRITE_BUS_n = 1'b0;
        #1;
        checks++;
        if (BUS !== 8'h0C || o_COUNT !== 3'd0 || {o_OPCODE, o_OPERAND} !== 8'h3C) begin
            failures++;
            $display("FAIL bus_both_low got bus=%h c=%0d cir=%h want bus=0c c=0 cir=3c",
                     BUS, o_COUNT, {o_OPCODE, o_OPERAND});
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i), 1'b1);
        #3;
        i_WRITE_BUS_n = 1'b0;
        tb_drv_en     = 1'b1;
        tb_drv_val    = 8'h50;
        i_CLEAR_n     = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o_OPCODE, o_OPERAND, o_VALID, o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW}
            !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got cir=%h v=%b c=%0d f=%b e=%b o=%b",
                     {o_OPCODE, o_OPERAND}, o_VALID, o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW);
        end
        checks++;
        if (BUS !== 8'h50) begin
            failures++;
            $display("FAIL async_reset_bus got=%h want=50", BUS);
        end
        set_idle();
        #2;
        i_CLEAR_n = 1'b1;
        push_word(8'h9E, 1'b1);
        checks++;
        if ({o_OPCODE, o_OPERAND} !== 8'h9E || o_VALID !== 1'b1 || o_COUNT !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_bypass got cir=%h v=%b c=%0d want cir=9e v=1 c=0",
                     {o_OPCODE, o_OPERAND}, o_VALID, o_COUNT);
        end
    endtask

    task automatic test_random();
        logic       rd_n;
        logic       wr_n;
        logic       nx_n;
        logic       fl_n;
        logic [7:0] d;
        int         n;
        for (int i = 0; i < 600; i++) begin
            rd_n = ($urandom_range(0, 2) == 0);
            wr_n = ($urandom_range(0, 9) != 0);
            nx_n = ($urandom_range(0, 1) == 0);
            fl_n = ($urandom_range(0, 29) != 0);
            d    = 8'($urandom);
            cycle(rd_n, wr_n, nx_n, fl_n, d);
            n = m_q.size();
            checks++;
            if ({o_OPCODE, o_OPERAND} !== m_cir || o_VALID !== m_valid) begin
                failures++;
                $display("FAIL rand_cir[%0d] got cir=%h v=%b want cir=%h v=%b",
                         i, {o_OPCODE, o_OPERAND}, o_VALID, m_cir, m_valid);
            end
            checks++;
            if (o_COUNT !== 3'(n) || o_FULL !== (n == DEPTH) || o_EMPTY !== (n == 0)
                || o_OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL rand_status[%0d] got c=%0d f=%b e=%b o=%b want c=%0d o=%b",
                         i, o_COUNT, o_FULL, o_EMPTY, o_OVERFLOW, n, m_ovf);
            end
            if ($urandom_range(0, 7) == 0) begin
                i_WRITE_BUS_n = 1'b0;
                #1;
                checks++;
                if (BUS !== {4'h0, m_cir[3:0]}) begin
                    failures++;
                    $display("FAIL rand_bus[%0d] got=%h want=%h", i, BUS, {4'h0, m_cir[3:0]});
                end
                set_idle();
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_bypass();
        test_fill_overflow();
        test_full_push_pop();
        test_flush();
        test_bus_drive();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
